// File: rtl/vr_change_send_ctrl.sv
// Replica change-send controller: picks live destinations (unicast or broadcast),
// fetches the log length, emits UDP metadata and forwards the log data stream.
module vr_change_send_ctrl #(
  parameter int unsigned NUM_REPLICAS = 3,
  parameter int unsigned REPLICA_W    = $clog2(NUM_REPLICAS),
  parameter int unsigned LEN_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    send_req,
  input  logic                    send_mode,
  input  logic [REPLICA_W-1:0]    self_idx,
  input  logic [REPLICA_W-1:0]    start_idx,
  input  logic [NUM_REPLICAS-1:0] replica_alive,
  output logic                    send_rdy,
  output logic                    init_state,
  output logic                    log_req_val,
  input  logic                    log_req_rdy,
  input  logic                    log_len_val,
  input  logic [LEN_W-1:0]        log_len,
  output logic                    meta_val,
  input  logic                    meta_rdy,
  output logic [REPLICA_W-1:0]    meta_dst,
  output logic [LEN_W-1:0]        meta_len,
  input  logic                    src_data_val,
  input  logic                    src_data_last,
  output logic                    src_data_rdy,
  output logic                    udp_data_val,
  output logic                    udp_data_last,
  input  logic                    udp_data_rdy,
  output logic                    send_done,
  output logic                    send_fail,
  output logic [REPLICA_W:0]      sent_cnt
);

  typedef enum logic [2:0] {
    StReady   = 3'd0,
    StScan    = 3'd1,
    StReqLog  = 3'd2,
    StWaitLog = 3'd3,
    StMetaOut = 3'd4,
    StDataOut = 3'd5,
    StNext    = 3'd6,
    StFinish  = 3'd7
  } state_e;

  localparam logic [REPLICA_W-1:0] LastIdx = REPLICA_W'(NUM_REPLICAS - 1);
  localparam logic [REPLICA_W:0]   NumCnt  = (REPLICA_W + 1)'(NUM_REPLICAS);

  state_e               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [REPLICA_W-1:0] self_q, self_d;
  logic [REPLICA_W-1:0] cand_q, cand_d;
  logic [REPLICA_W-1:0] dst_q, dst_d;
  logic [REPLICA_W:0]   scan_cnt_q, scan_cnt_d;
  logic [REPLICA_W:0]   sent_cnt_q, sent_cnt_d;
  logic [LEN_W-1:0]     meta_len_q, meta_len_d;

  // Out-of-range candidates shift the one-hot to zero and read as dead.
  logic [NUM_REPLICAS-1:0] cand_onehot;
  logic                    cand_alive;
  logic                    eligible;
  logic [REPLICA_W:0]      scan_cnt_inc;

  assign cand_onehot  = NUM_REPLICAS'(1) << cand_q;
  assign cand_alive   = |(replica_alive & cand_onehot);
  assign eligible     = cand_alive && (!mode_q || (cand_q != self_q));
  assign scan_cnt_inc = scan_cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StReady;
      mode_q     <= 1'b0;
      self_q     <= '0;
      cand_q     <= '0;
      dst_q      <= '0;
      scan_cnt_q <= '0;
      sent_cnt_q <= '0;
      meta_len_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      self_q     <= self_d;
      cand_q     <= cand_d;
      dst_q      <= dst_d;
      scan_cnt_q <= scan_cnt_d;
      sent_cnt_q <= sent_cnt_d;
      meta_len_q <= meta_len_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    self_d        = self_q;
    cand_d        = cand_q;
    dst_d         = dst_q;
    scan_cnt_d    = scan_cnt_q;
    sent_cnt_d    = sent_cnt_q;
    meta_len_d    = meta_len_q;
    send_rdy      = 1'b0;
    init_state    = 1'b0;
    log_req_val   = 1'b0;
    meta_val      = 1'b0;
    src_data_rdy  = 1'b0;
    udp_data_val  = 1'b0;
    udp_data_last = 1'b0;
    send_done     = 1'b0;
    send_fail     = 1'b0;

    unique case (state_q)
      StReady: begin
        send_rdy   = 1'b1;
        init_state = 1'b1;
        if (send_req) begin
          mode_d     = send_mode;
          self_d     = self_idx;
          cand_d     = send_mode ? '0 : start_idx;
          scan_cnt_d = '0;
          sent_cnt_d = '0;
          state_d    = StScan;
        end
      end
      StScan: begin
        if (eligible) begin
          dst_d   = cand_q;
          state_d = StReqLog;
        end else begin
          scan_cnt_d = scan_cnt_inc;
          if (mode_q) begin
            // Broadcast walks upward and stops after the last index.
            if (cand_q >= LastIdx) state_d = StFinish;
            else                   cand_d  = cand_q + 1'b1;
          end else begin
            cand_d = (cand_q == '0) ? LastIdx : cand_q - 1'b1;
            if (scan_cnt_inc >= NumCnt) state_d = StFinish;
          end
        end
      end
      StReqLog: begin
        log_req_val = 1'b1;
        if (log_req_rdy) state_d = StWaitLog;
      end
      StWaitLog: begin
        if (log_len_val) begin
          meta_len_d = log_len;
          state_d    = StMetaOut;
        end
      end
      StMetaOut: begin
        meta_val = 1'b1;
        if (meta_rdy) state_d = StDataOut;
      end
      StDataOut: begin
        udp_data_val  = src_data_val;
        udp_data_last = src_data_last;
        src_data_rdy  = udp_data_rdy;
        if (src_data_val && udp_data_rdy && src_data_last) begin
          sent_cnt_d = sent_cnt_q + 1'b1;
          state_d    = StNext;
        end
      end
      StNext: begin
        if (!mode_q || (dst_q == LastIdx)) begin
          state_d = StFinish;
        end else begin
          cand_d  = dst_q + 1'b1;
          state_d = StScan;
        end
      end
      StFinish: begin
        send_done = (sent_cnt_q != '0);
        send_fail = (sent_cnt_q == '0);
        state_d   = StReady;
      end
      default: begin
`ifndef SYNTHESIS
        send_rdy      = 1'bx;
        init_state    = 1'bx;
        log_req_val   = 1'bx;
        meta_val      = 1'bx;
        src_data_rdy  = 1'bx;
        udp_data_val  = 1'bx;
        udp_data_last = 1'bx;
        send_done     = 1'bx;
        send_fail     = 1'bx;
`endif
        state_d = StReady;
      end
    endcase
  end

  assign meta_dst = dst_q;
  assign meta_len = meta_len_q;
  assign sent_cnt = sent_cnt_q;

endmodule

// File: tb/tb_vr_change_send_ctrl.sv
// Scoreboard bench for vr_change_send_ctrl: directed operations push expected
// metadata, beats and completions; a monitor pops and compares on each output event.
module tb_vr_change_send_ctrl;

  localparam int N = 3;
  localparam int W = 2;
  localparam int L = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         send_req, send_mode;
  logic [W-1:0] self_idx, start_idx;
  logic [N-1:0] replica_alive;
  logic         send_rdy, init_state;
  logic         log_req_val, log_req_rdy, log_len_val;
  logic [L-1:0] log_len;
  logic         meta_val, meta_rdy;
  logic [W-1:0] meta_dst;
  logic [L-1:0] meta_len;
  logic         src_data_val, src_data_last, src_data_rdy;
  logic         udp_data_val, udp_data_last, udp_data_rdy;
  logic         send_done, send_fail;
  logic [W:0]   sent_cnt;

  vr_change_send_ctrl #(.NUM_REPLICAS(N), .REPLICA_W(W), .LEN_W(L)) dut (
    .clk           (clk),
    .rst           (rst),
    .send_req      (send_req),
    .send_mode     (send_mode),
    .self_idx      (self_idx),
    .start_idx     (start_idx),
    .replica_alive (replica_alive),
    .send_rdy      (send_rdy),
    .init_state    (init_state),
    .log_req_val   (log_req_val),
    .log_req_rdy   (log_req_rdy),
    .log_len_val   (log_len_val),
    .log_len       (log_len),
    .meta_val      (meta_val),
    .meta_rdy      (meta_rdy),
    .meta_dst      (meta_dst),
    .meta_len      (meta_len),
    .src_data_val  (src_data_val),
    .src_data_last (src_data_last),
    .src_data_rdy  (src_data_rdy),
    .udp_data_val  (udp_data_val),
    .udp_data_last (udp_data_last),
    .udp_data_rdy  (udp_data_rdy),
    .send_done     (send_done),
    .send_fail     (send_fail),
    .sent_cnt      (sent_cnt)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W+L-1:0] exp_meta[$];
  logic           exp_beat[$];
  logic [W+2:0]   exp_res[$];   // {done, fail, sent_cnt}

  int          log_cnt = 0;
  int          beats_seen = 0;
  logic [L-1:0] cur_len = '0;
  int          n_beats = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Log responder: random accept, length pulse the cycle after the handshake.
  initial begin
    logic hs;
    log_req_rdy = 1'b0;
    log_len_val = 1'b0;
    log_len     = '0;
    forever begin
      @(negedge clk);
      hs = log_req_val && log_req_rdy && !rst;
      @(posedge clk);
      #1;
      log_len_val = hs;
      log_len     = hs ? cur_len : '0;
      log_req_rdy = 1'($urandom_range(0, 1));
      if (hs) log_cnt++;
    end
  end

  // Random ready on metadata and UDP sinks.
  initial begin
    meta_rdy     = 1'b0;
    udp_data_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      meta_rdy     = 1'($urandom_range(0, 1));
      udp_data_rdy = 1'($urandom_range(0, 1));
    end
  end

  // Log data source: n_beats-beat stream per message, random gaps.
  initial begin
    logic hs;
    int   beat_idx;
    beat_idx      = 0;
    src_data_val  = 1'b0;
    src_data_last = 1'b0;
    forever begin
      @(negedge clk);
      hs = src_data_val && src_data_rdy && !rst;
      @(posedge clk);
      #1;
      if (rst)     beat_idx = 0;
      else if (hs) beat_idx = src_data_last ? 0 : beat_idx + 1;
      src_data_val  = (n_beats != 0) && ($urandom_range(0, 3) != 0);
      src_data_last = (beat_idx == n_beats - 1);
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_beat.delete();
      end else begin
        if (meta_val && meta_rdy) begin
          chk("meta_expected", 32'(exp_meta.size() != 0), 1);
          if (exp_meta.size() != 0) chk("meta_dst_len", {meta_dst, meta_len}, exp_meta.pop_front());
        end
        if (udp_data_val && udp_data_rdy) begin
          beats_seen++;
          chk("beat_expected", 32'(exp_beat.size() != 0), 1);
          if (exp_beat.size() != 0) chk("beat_last", udp_data_last, exp_beat.pop_front());
        end
        if (send_done || send_fail) begin
          chk("result_expected", 32'(exp_res.size() != 0), 1);
          if (exp_res.size() != 0) chk("result", {send_done, send_fail, sent_cnt}, exp_res.pop_front());
        end
      end
    end
  end

  task automatic push_msg(input logic [W-1:0] dst, input logic [L-1:0] len, input int beats);
    exp_meta.push_back({dst, len});
    for (int i = 0; i < beats; i++) exp_beat.push_back(i == beats - 1);
  endtask

  task automatic check_idle(input string name);
    chk(name, {send_rdy, init_state, log_req_val, meta_val, src_data_rdy, udp_data_val,
               udp_data_last, send_done, send_fail, meta_dst, meta_len, sent_cnt},
        {2'b11, 7'b0, {W{1'b0}}, {L{1'b0}}, {(W + 1){1'b0}}});
  endtask

  task automatic start_op(input logic mode, input logic [W-1:0] self, input logic [W-1:0] start,
                          input logic [N-1:0] alive, input logic [L-1:0] len, input int beats);
    @(posedge clk);
    #1;
    cur_len       = len;
    n_beats       = beats;
    send_mode     = mode;
    self_idx      = self;
    start_idx     = start;
    replica_alive = alive;
    send_req      = 1'b1;
    @(negedge clk);
    chk("accept_ready", send_rdy, 1);
    @(posedge clk);
    #1;
    send_req = 1'b0;
  endtask

  task automatic run_op(input string name, input logic mode, input logic [W-1:0] self,
                        input logic [W-1:0] start, input logic [N-1:0] alive,
                        input logic [L-1:0] len, input int beats, input int exp_logs,
                        output int cyc);
    int l0;
    l0  = log_cnt;
    start_op(mode, self, start, alive, len, beats);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!send_rdy && cyc < 400);
    chk({name, "_timeout"}, 32'(cyc < 400), 1);
    chk({name, "_log_reqs"}, log_cnt - l0, exp_logs);
    chk({name, "_pulse_low"}, {send_done, send_fail}, 0);
    chk({name, "_queues_empty"}, exp_meta.size() + exp_beat.size() + exp_res.size(), 0);
  endtask

  initial begin
    int cyc;
    int b0;
    rst           = 1'b1;
    send_req      = 1'b0;
    send_mode     = 1'b0;
    self_idx      = '0;
    start_idx     = '0;
    replica_alive = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset_state");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset_idle");

    // Unicast start 2, alive 011: 2 skipped, 1 chosen.
    push_msg(2'd1, 16'd32, 2);
    exp_res.push_back({2'b10, 3'd1});
    run_op("uni_skip", 1'b0, 2'd0, 2'd2, 3'b011, 16'd32, 2, 1, cyc);

    // Unicast start 0, alive 100: wraps to 2.
    push_msg(2'd2, 16'h10, 3);
    exp_res.push_back({2'b10, 3'd1});
    run_op("uni_wrap", 1'b0, 2'd0, 2'd0, 3'b100, 16'h10, 3, 1, cyc);

    // Broadcast self 1, all alive: dst 0 then 2.
    push_msg(2'd0, 16'd64, 2);
    push_msg(2'd2, 16'd64, 2);
    exp_res.push_back({2'b10, 3'd2});
    run_op("bcast_all", 1'b1, 2'd1, 2'd0, 3'b111, 16'd64, 2, 2, cyc);

    // Unicast may target self.
    push_msg(2'd1, 16'd5, 1);
    exp_res.push_back({2'b10, 3'd1});
    run_op("uni_self", 1'b0, 2'd1, 2'd1, 3'b010, 16'd5, 1, 1, cyc);

    // Broadcast self 2, alive 101: only dst 0, self at last index skipped.
    push_msg(2'd0, 16'd100, 1);
    exp_res.push_back({2'b10, 3'd1});
    run_op("bcast_self_last", 1'b1, 2'd2, 2'd0, 3'b101, 16'd100, 1, 1, cyc);

    // No live replica, both modes: fail pulse within NUM_REPLICAS+2 cycles.
    exp_res.push_back({2'b01, 3'd0});
    run_op("uni_none", 1'b0, 2'd0, 2'd1, 3'b000, 16'd9, 1, 0, cyc);
    chk("uni_none_latency", 32'(cyc <= N + 2), 1);
    exp_res.push_back({2'b01, 3'd0});
    run_op("bcast_none", 1'b1, 2'd0, 2'd0, 3'b000, 16'd9, 1, 0, cyc);
    chk("bcast_none_latency", 32'(cyc <= N + 2), 1);

    // Broadcast self 0, alive 001: only self is alive -> fail.
    exp_res.push_back({2'b01, 3'd0});
    run_op("bcast_only_self", 1'b1, 2'd0, 2'd0, 3'b001, 16'd9, 1, 0, cyc);

    // 4-beat stream under backpressure, reset after the second beat.
    push_msg(2'd1, 16'd48, 4);
    b0 = beats_seen;
    start_op(1'b0, 2'd0, 2'd1, 3'b010, 16'd48, 4);
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
    end while (beats_seen < b0 + 2 && cyc < 400);
    chk("rst_mid_wait", 32'(cyc < 400), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_async_ready", {send_rdy, init_state, udp_data_val, src_data_rdy}, 4'b1100);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("rst_mid_idle");
    chk("rst_mid_beats", beats_seen - b0, 2);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_idle("rst_mid_no_pulse");
    chk("rst_mid_queues", exp_meta.size() + exp_beat.size() + exp_res.size(), 0);

    // Normal operation after mid-transfer reset.
    push_msg(2'd1, 16'd77, 4);
    exp_res.push_back({2'b10, 3'd1});
    run_op("recover", 1'b0, 2'd0, 2'd2, 3'b011, 16'd77, 4, 1, cyc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vr_change_send_ctrl.md
VR_CHANGE_SEND_CTRL -- requirements
Module: vr_change_send_ctrl

Interface
REQ-001 Parameter NUM_REPLICAS, default 3, replica count (2..16).
REQ-002 Parameter REPLICA_W, default $clog2(NUM_REPLICAS), replica index width.
REQ-003 Parameter LEN_W, default 16, log length width.
REQ-004 Ports SHALL be:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- send_req  in  1  start request, accepted when send_rdy=1.
- send_mode  in  1  0 unicast to first live candidate, 1 broadcast to all live non-self replicas.
- self_idx  in  REPLICA_W  own replica index.
- start_idx  in  REPLICA_W  first unicast candidate.
- replica_alive  in  NUM_REPLICAS  liveness mask.
- send_rdy  out  1  idle.
- init_state  out  1  high in READY.
- log_req_val / log_req_rdy  out/in  1  log read request handshake.
- log_len_val  in  1  log length valid (single-cycle pulse).
- log_len  in  LEN_W  log length in bytes.
- meta_val / meta_rdy  out/in  1  UDP metadata handshake.
- meta_dst  out  REPLICA_W  current destination.
- meta_len  out  LEN_W  stored log length.
- src_data_val, src_data_last  in  1  log data stream.
- src_data_rdy  out  1  log data ready.
- udp_data_val, udp_data_last  out  1  UDP data stream.
- udp_data_rdy  in  1  UDP data ready.
- send_done  out  1  one-cycle pulse, at least one message sent.
- send_fail  out  1  one-cycle pulse, no destination found.
- sent_cnt  out  REPLICA_W+1  messages sent in current/last operation.

Function
REQ-005 States READY=0, SCAN=1, REQ_LOG=2, WAIT_LOG=3, META_OUT=4, DATA_OUT=5, NEXT=6, FINISH=7; 3-bit register.
REQ-006 READY: send_rdy=1, init_state=1; on send_req, latch send_mode, self_idx, start_idx; cand:=start_idx (unicast) or 0 (broadcast); scan_cnt:=0; sent_cnt:=0; go to SCAN.
REQ-007 SCAN, one candidate per cycle: eligible = replica_alive[cand] and (unicast or cand!=self_idx); if eligible, go to REQ_LOG with dst:=cand; else scan_cnt+1.
REQ-008 Unicast scan decrements cand modulo NUM_REPLICAS (0 wraps to NUM_REPLICAS-1); broadcast increments cand, no wrap.
REQ-009 Scan exhaustion (scan_cnt reaches NUM_REPLICAS unicast, or cand passes NUM_REPLICAS-1 broadcast) goes to FINISH.
REQ-010 REQ_LOG: log_req_val=1; on log_req_rdy go to WAIT_LOG.
REQ-011 WAIT_LOG: on log_len_val, store log_len into meta_len, go to META_OUT.
REQ-012 META_OUT: meta_val=1, meta_dst=dst; on meta_rdy go to DATA_OUT.
REQ-013 DATA_OUT: udp_data_val=src_data_val, src_data_rdy=udp_data_rdy, udp_data_last=src_data_last, all combinational; on val&rdy&last, sent_cnt+1, go to NEXT.
REQ-014 NEXT: unicast goes to FINISH; broadcast sets cand:=dst+1, goes to SCAN, or FINISH if dst=NUM_REPLICAS-1.
REQ-015 FINISH, one cycle: send_done=1 if sent_cnt!=0 else send_fail=1; go to READY.
REQ-016 In every state except DATA_OUT: src_data_rdy=0, udp_data_val=0; outside REQ_LOG/META_OUT, log_req_val=0 and meta_val=0.
REQ-017 Once asserted, log_req_val and meta_val SHALL hold until accepted; meta_dst and meta_len stable while meta_val=1.
REQ-018 send_req outside READY is ignored; replica_alive is sampled per SCAN cycle only.
REQ-019 Illegal state encodings force X on outputs in simulation only.

Reset
REQ-020 rst asserted at any time: state:=READY; sent_cnt, meta_len, dst, cand, scan_cnt:=0; outputs send_rdy=1, init_state=1, all other outputs 0.
REQ-021 Reset mid-transfer drops the in-flight message; no done/fail pulse.

Verification
REQ-022 NUM_REPLICAS=3, unicast, start_idx=2, alive=3'b011 -> scan 2 (skip), then 1 chosen; meta_dst=1; send_done, sent_cnt=1.
REQ-023 Unicast, start_idx=0, alive=3'b100 -> wraps to 2; meta_dst=2; send_done.
REQ-024 Broadcast, self_idx=1, alive=3'b111, log_len=64 -> two messages (dst 0 then 2), each meta_len=64, two log requests; sent_cnt=2, send_done.
REQ-025 alive=3'b000 (either mode) -> no log_req_val, send_fail one cycle, back to READY in ≤ NUM_REPLICAS+2 cycles.
REQ-026 DATA_OUT with random udp_data_rdy backpressure, 4-beat stream -> beats pass unaltered, no loss/duplication; rst asserted at beat 2 -> state READY, send_rdy=1, no done pulse.
